// File: rtl/rm_key_manager_pkg.sv
// Shared types for the random-modulo key sequencer and the cache index hash.
package rm_pkg;

    localparam int unsigned RM_RAND_WIDTH = 16;
    localparam int unsigned RM_KEY_WORDS  = 4;
    localparam int unsigned RM_KEY_BITS   = RM_RAND_WIDTH * RM_KEY_WORDS;

    typedef logic [RM_KEY_BITS-1:0] rm_key_t;

    typedef enum logic [1:0] {
        RM_IDLE,
        RM_FLUSH,
        RM_DRAW,
        RM_COMMIT
    } rm_state_t;

    // Index width that stays at least one bit for single-entry vectors.
    function automatic int unsigned rm_clog2(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rm_key_manager_rr_arbiter.sv
// Round-robin arbiter: the search starts at the requester after the last one granted.
module rr_arbiter
    import rm_pkg::*;
#(
    parameter  int unsigned NUM_REQUESTERS = 2,
    localparam int unsigned IW             = rm_clog2(NUM_REQUESTERS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQUESTERS-1:0] request,
    input  logic                      update_lru,
    output logic [NUM_REQUESTERS-1:0] grant,
    output logic [IW-1:0]             grant_idx,
    output logic                      grant_valid
);

    logic [IW-1:0] next_ptr;
    logic [IW-1:0] cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
            cand = IW'((32'(next_ptr) + i) % NUM_REQUESTERS);
            if (!grant_valid && request[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            next_ptr <= '0;
        end else if (update_lru && grant_valid) begin
            next_ptr <= (grant_idx == IW'(NUM_REQUESTERS - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/rm_key_manager.sv
// Random-modulo key sequencer: flushes a cache, draws KEY_WORDS prng words into a
// shadow register and commits them as that cache's new key in a single edge.
module rm_key_manager
    import rm_pkg::*;
#(
    parameter  int unsigned NUM_CLIENTS = 2,
    parameter  int unsigned RAND_WIDTH  = RM_RAND_WIDTH,
    parameter  int unsigned KEY_WORDS   = RM_KEY_WORDS,
    localparam int unsigned KEY_BITS    = RAND_WIDTH * KEY_WORDS
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [RAND_WIDTH-1:0]           rand_i,
    input  logic [31:0]                     period_i,
    input  logic [NUM_CLIENTS-1:0]          rekey_req,
    output logic [NUM_CLIENTS-1:0]          flush_req,
    input  logic [NUM_CLIENTS-1:0]          flush_done,
    output logic [NUM_CLIENTS-1:0]          rekey_done,
    output logic [NUM_CLIENTS*KEY_BITS-1:0] key_o,
    output logic                            busy
);

    localparam int unsigned CW = rm_clog2(NUM_CLIENTS);
    localparam int unsigned WW = rm_clog2(KEY_WORDS);

    rm_state_t              state, state_next;
    logic [CW-1:0]          client_q;
    logic [WW-1:0]          cnt_q;
    logic [NUM_CLIENTS-1:0] pending_q, pending_next;
    logic [31:0]            timer_q;
    logic [KEY_BITS-1:0]    shadow_q, shadow_upd;
    logic [KEY_BITS-1:0]    key_q [NUM_CLIENTS];

    logic [NUM_CLIENTS-1:0] arb_req, arb_grant, client_oh;
    logic [CW-1:0]          arb_idx;
    logic                   arb_valid;
    logic                   grant_edge, expire, last_word;

    rr_arbiter #(
        .NUM_REQUESTERS (NUM_CLIENTS)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .request     (arb_req),
        .update_lru  (grant_edge),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    always_comb begin
        arb_req    = (state == RM_IDLE) ? (pending_q | rekey_req) : '0;
        expire     = (period_i != 32'd0) && (timer_q >= period_i - 32'd1);
        last_word  = (state == RM_DRAW) && (cnt_q == WW'(KEY_WORDS - 1));
        client_oh  = NUM_CLIENTS'(1) << client_q;
        state_next = state;
        grant_edge = 1'b0;
        case (state)
            RM_IDLE: begin
                if (arb_valid) begin
                    state_next = RM_FLUSH;
                    grant_edge = 1'b1;
                end
            end
            RM_FLUSH:  if (flush_done[client_q]) state_next = RM_DRAW;
            RM_DRAW:   if (last_word) state_next = RM_COMMIT;
            RM_COMMIT: state_next = RM_IDLE;
            default:   state_next = RM_IDLE;
        endcase

        // Clearing the granted bit beats a same-cycle request for it (that request is
        // the one being serviced); a timer expiry is a fresh event and re-arms everyone.
        pending_next = ((pending_q | rekey_req) & ~(grant_edge ? arb_grant : '0))
                     | {NUM_CLIENTS{expire}};

        shadow_upd = shadow_q;
        shadow_upd[cnt_q*RAND_WIDTH +: RAND_WIDTH] = rand_i;

        flush_req  = (state == RM_FLUSH)  ? client_oh : '0;
        rekey_done = (state == RM_COMMIT) ? client_oh : '0;
        busy       = (state != RM_IDLE);

        key_o = '0;
        for (int unsigned c = 0; c < NUM_CLIENTS; c++) begin
            key_o[c*KEY_BITS +: KEY_BITS] = key_q[c];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RM_IDLE;
            client_q  <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
            timer_q   <= '0;
            shadow_q  <= '0;
            for (int unsigned c = 0; c < NUM_CLIENTS; c++) begin
                key_q[c] <= '0;
            end
        end else begin
            state     <= state_next;
            pending_q <= pending_next;

            if (period_i == 32'd0 || expire) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + 32'd1;
            end

            if (grant_edge) begin
                client_q <= arb_idx;
            end

            if (state == RM_FLUSH) begin
                cnt_q <= '0;
            end else if (state == RM_DRAW) begin
                cnt_q    <= cnt_q + WW'(1);
                shadow_q <= shadow_upd;
            end

            // The last word goes straight from rand_i into the key, so the key
            // register only ever holds a complete draw.
            if (last_word) begin
                key_q[client_q] <= shadow_upd;
            end
        end
    end

endmodule

// File: tb/tb_rm_key_manager.sv
// Scoreboard bench for rm_key_manager: expected keys are queued at flush_done time.
module tb_rm_key_manager;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [15:0]  rand_i;
    logic [31:0]  period_i = '0;
    logic [1:0]   rekey_req = '0;
    logic [1:0]   flush_req;
    logic [1:0]   flush_done = '0;
    logic [1:0]   rekey_done;
    logic [127:0] key_o;
    logic         busy;

    typedef struct {
        int          client;
        logic [63:0] key;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          done_log[$];
    logic [63:0] model_key [2];
    int          done_cnt [2];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          fl_delay = 2;
    int          flush_count = 0;
    int          last_flush_cyc = 0;

    rm_key_manager #(
        .NUM_CLIENTS (2),
        .RAND_WIDTH  (16),
        .KEY_WORDS   (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rand_i     (rand_i),
        .period_i   (period_i),
        .rekey_req  (rekey_req),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .rekey_done (rekey_done),
        .key_o      (key_o),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign rand_i = 16'h1000 + cyc[15:0];

    function automatic logic [15:0] rnd(input int c);
        logic [31:0] v;
        v = c;
        return 16'h1000 + v[15:0];
    endfunction

    // Key drawn after flush_done in cycle f: words from cycles f+1..f+4, word 0 in the LSBs.
    function automatic logic [63:0] key_from(input int f);
        return {rnd(f + 4), rnd(f + 3), rnd(f + 2), rnd(f + 1)};
    endfunction

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Flush responder: a stray flush_done on the other client first, then the real one.
    initial begin
        int age;
        int c;
        age = 0;
        forever begin
            @(negedge clk);
            flush_done = '0;
            if (!reset || flush_req == 2'b00) begin
                age = 0;
            end else begin
                age++;
                if (age == 1 && fl_delay > 1) flush_done = ~flush_req;
                if (age == fl_delay) begin
                    c = flush_req[1] ? 1 : 0;
                    flush_done[c] = 1'b1;
                    sb.push_back('{client: c, key: key_from(cyc), cyc: cyc + 5});
                    last_flush_cyc = cyc;
                    flush_count++;
                end
            end
        end
    end

    // Monitor: protocol checks and commit scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (flush_req != 2'b00) check_val("flush_onehot", 128'($onehot0(flush_req)), 128'd1);
                if (rekey_done != 2'b00) begin
                    if (sb.size() == 0) begin
                        check_val("done_unexpected", 128'(rekey_done), 128'd0);
                    end else begin
                        e = sb.pop_front();
                        check_val("done_client", 128'(rekey_done), 128'(2'b01 << e.client));
                        check_val("done_cycle", 128'(cyc), 128'(e.cyc));
                        model_key[e.client] = e.key;
                        done_cnt[e.client]++;
                        done_log.push_back(e.client);
                    end
                end
                check_val("key_o", key_o, {model_key[1], model_key[0]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic pulse(input logic [1:0] r);
        rekey_req = r;
        @(negedge clk);
        rekey_req = '0;
    endtask

    task automatic clear_model();
        sb.delete();
        model_key[0] = '0;
        model_key[1] = '0;
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int quiet;
        quiet = 0;
        for (int i = 0; i < 600 && quiet < 3; i++) begin
            @(negedge clk);
            quiet = busy ? 0 : quiet + 1;
        end
        if (quiet < 3) check_val(tag, 128'(quiet), 128'd3);
    endtask

    task automatic wait_flush(input string tag, input int fc);
        int i;
        for (i = 0; i < 100 && flush_count == fc; i++) begin
            @(negedge clk);
            #1;
        end
        if (flush_count == fc) check_val(tag, 128'(flush_count), 128'(fc + 1));
    endtask

    initial begin
        int t0, b0, b1, nl, fc;
        model_key[0] = '0;
        model_key[1] = '0;
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);

        // Idle after reset
        repeat (100) @(negedge clk);
        check_val("t1_key", key_o, '0);
        check_val("t1_flush_req", 128'(flush_req), 128'd0);
        check_val("t1_busy", 128'(busy), 128'd0);
        check_val("t1_done_count", 128'(done_cnt[0] + done_cnt[1]), 128'd0);

        // Single rekey of client 0 with exact latency
        fl_delay = 5;
        t0 = cyc;
        pulse(2'b01);
        check_val("t2_flush_req", 128'(flush_req), 128'(2'b01));
        check_val("t2_busy", 128'(busy), 128'd1);
        repeat (8) @(negedge clk);
        check_val("t2_done_early", 128'(rekey_done), 128'd0);
        @(negedge clk);
        check_val("t2_done", 128'(rekey_done), 128'(2'b01));
        check_val("t2_key0", 128'(key_o[63:0]), 128'(key_from(t0 + 5)));
        check_val("t2_key1", 128'(key_o[127:64]), 128'd0);
        @(negedge clk);
        check_val("t2_done_pulse", 128'(rekey_done), 128'd0);
        wait_idle("t2_idle");

        // Both clients at once, round robin from client 0
        fl_delay = 3;
        do_reset();
        b0 = done_cnt[0];
        b1 = done_cnt[1];
        nl = done_log.size();
        pulse(2'b11);
        wait_idle("t3_idle");
        check_val("t3_cnt0", 128'(done_cnt[0] - b0), 128'd1);
        check_val("t3_cnt1", 128'(done_cnt[1] - b1), 128'd1);
        if (done_log.size() >= nl + 2) begin
            check_val("t3_first", 128'(done_log[nl]), 128'd0);
            check_val("t3_second", 128'(done_log[nl + 1]), 128'd1);
        end else begin
            check_val("t3_log_len", 128'(done_log.size() - nl), 128'd2);
        end

        // Periodic rekey: 300 cycles at period 50 gives six expiries
        fl_delay = 2;
        b0 = done_cnt[0];
        b1 = done_cnt[1];
        nl = done_log.size();
        period_i = 32'd50;
        repeat (300) @(posedge clk);
        @(negedge clk);
        period_i = 32'd0;
        wait_idle("t4_idle");
        check_val("t4_cnt0", 128'(done_cnt[0] - b0), 128'd6);
        check_val("t4_cnt1", 128'(done_cnt[1] - b1), 128'd6);
        for (int k = nl; k < done_log.size(); k++) begin
            check_val("t4_order", 128'(done_log[k]), 128'((k - nl) % 2));
        end

        // Request for client 1 while it is in DRAW queues a second rekey
        b0 = done_cnt[0];
        b1 = done_cnt[1];
        fc = flush_count;
        pulse(2'b10);
        wait_flush("t5_flush_timeout", fc);
        repeat (2) @(negedge clk);
        check_val("t5_busy_draw", 128'(busy), 128'd1);
        pulse(2'b10);
        wait_idle("t5_idle");
        check_val("t5_cnt1", 128'(done_cnt[1] - b1), 128'd2);
        check_val("t5_cnt0", 128'(done_cnt[0] - b0), 128'd0);

        // Reset in the middle of DRAW word 2
        fc = flush_count;
        pulse(2'b01);
        wait_flush("t6_flush_timeout", fc);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        clear_model();
        #1;
        check_val("t6_key", key_o, '0);
        check_val("t6_busy", 128'(busy), 128'd0);
        check_val("t6_flush_req", 128'(flush_req), 128'd0);
        check_val("t6_done", 128'(rekey_done), 128'd0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        b0 = done_cnt[0];
        pulse(2'b01);
        wait_idle("t6_idle");
        check_val("t6_cnt0", 128'(done_cnt[0] - b0), 128'd1);
        check_val("t6_key_after", 128'(key_o[63:0]), 128'(model_key[0]));
        check_val("t6_sb_empty", 128'(sb.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
